// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE matrix controller.
//   N         : matrix dimension (columns/rows)
//   SEL_*     : per-column streaming-mode codes driven on sel
//   state_t   : controller FSM states
//   cfg_is_legal : start-time configuration check
package pe_ctrl_pkg;

  localparam int N = 11;

  localparam logic [1:0] SEL_EXT  = 2'd0;  // load from Bus_IF
  localparam logic [1:0] SEL_DL   = 2'd1;  // shift from m_in_1 (lower-left)
  localparam logic [1:0] SEL_UR   = 2'd2;  // shift from m_in_2 (upper-right)
  localparam logic [1:0] SEL_HOLD = 2'd3;  // recirculate via m_in_3

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_W,
    S_LOAD_W,
    S_FILL,
    S_STREAM,
    S_DRAIN
  } state_t;

  // K must select at least one and at most N columns; a job must carry beats.
  function automatic logic cfg_is_legal(input logic [3:0] k, input logic beats_nonzero);
    return (k != 4'd0) && (k <= 4'(N)) && beats_nonzero;
  endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Delay line that follows feature beats through the PE matrix so that
// p_valid/p_last line up with the products appearing on Bus_P.
// Ports:
//   CLK       clock, rising edge
//   clr       synchronous clear (reset or abort), flushes in-flight beats
//   in_valid  accepted feature beat this cycle
//   in_last   the accepted beat is the job's final beat
//   out_valid in_valid delayed by PIPE_LAT cycles
//   out_last  in_last delayed by PIPE_LAT cycles
module pe_valid_pipe #(
  parameter int PIPE_LAT = 2
) (
  input  logic CLK,
  input  logic clr,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [PIPE_LAT-1:0] valid_sr;
  logic [PIPE_LAT-1:0] last_sr;

  always_ff @(posedge CLK) begin
    if (clr) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      last_sr[0]  <= in_valid & in_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[PIPE_LAT-1];
  assign out_last  = last_sr[PIPE_LAT-1];

endmodule

// File: rtl/pe_matrix_ctrl.sv
// Sequencer for the 11x11 PE matrix. A job clears the weights, loads K
// weight columns, then streams cfg_beats feature beats while steering the
// per-column mode selects, and finally drains the matrix pipeline.
// Ports:
//   CLK, RST                clock; synchronous active-high reset
//   start, abort            job start pulse / synchronous abort
//   cfg_k, cfg_beats, cfg_dir  job configuration, sampled on accepted start
//   busy, done, cfg_err     job status (done/cfg_err are 1-cycle pulses)
//   rst_w                   weight clear to the matrix
//   w_valid, w_load, w_col  weight column handshake and column index
//   if_valid, if_ready      feature beat handshake
//   sel                     per-column mode select, packed [N-1:0][1:0]
//   p_valid, p_last         Bus_P product validity and final-beat flag
module pe_matrix_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            cfg_k,
  input  logic [CNT_W-1:0]      cfg_beats,
  input  logic                  cfg_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  rst_w,
  input  logic                  w_valid,
  output logic                  w_load,
  output logic [3:0]            w_col,
  input  logic                  if_valid,
  output logic                  if_ready,
  output logic [N-1:0][1:0]     sel,
  output logic                  p_valid,
  output logic                  p_last
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t           state, state_nx;
  logic [3:0]       k_q;
  logic [CNT_W-1:0] beats_q;
  logic             dir_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             done_q, done_nx;
  logic             cfg_err_q, cfg_err_nx;
  logic             start_ok;
  logic             hs;
  logic             final_beat;
  logic             last_col;

  assign start_ok   = start && cfg_is_legal(cfg_k, |cfg_beats);
  assign if_ready   = (state == S_FILL) || (state == S_STREAM);
  assign hs         = if_ready && if_valid;
  // beat_cnt holds beats already accepted, so the FILL beat is final when cfg_beats == 1.
  assign final_beat = hs && (beat_cnt == beats_q - CNT_W'(1));
  assign last_col   = (w_col == k_q - 4'd1);
  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK) begin
    if (RST || abort) begin
      state     <= S_IDLE;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      done_q    <= done_nx;
      cfg_err_q <= cfg_err_nx;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nx   = state;
    done_nx    = 1'b0;
    cfg_err_nx = 1'b0;
    rst_w      = 1'b0;
    w_load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ok)   state_nx   = S_CLR_W;
        else if (start) cfg_err_nx = 1'b1;
      end
      S_CLR_W: begin
        rst_w    = 1'b1;
        state_nx = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_load = w_valid;
        if (w_valid && last_col) state_nx = S_FILL;
      end
      S_FILL: begin
        if (hs) state_nx = final_beat ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (final_beat) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(PIPE_LAT - 1)) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job configuration and progress counters.
  always_ff @(posedge CLK) begin
    if (RST || abort) begin
      k_q       <= '0;
      beats_q   <= '0;
      dir_q     <= 1'b0;
      w_col     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == S_IDLE && start_ok) begin
        k_q      <= cfg_k;
        beats_q  <= cfg_beats;
        dir_q    <= cfg_dir;
        w_col    <= '0;
        beat_cnt <= '0;
      end
      // Return to column 0 after the last column so w_col rests at 0 outside LOAD_W.
      if (w_load) w_col <= last_col ? 4'd0 : w_col + 4'd1;
      if (hs)     beat_cnt <= beat_cnt + CNT_W'(1);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // Column modes only change on an accepted beat; a gap recirculates every
  // column so the matrix contents stay aligned with the beat stream.
  always_comb begin
    sel = {N{SEL_HOLD}};
    if (hs) begin
      for (int c = 0; c < N; c++) begin
        if (4'(c) < k_q) begin
          if (state == S_FILL || 4'(c) == k_q - 4'd1) sel[c] = SEL_EXT;
          else                                         sel[c] = dir_q ? SEL_UR : SEL_DL;
        end
      end
    end
  end

  pe_valid_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_pipe (
    .CLK       (CLK),
    .clr       (RST | abort),
    .in_valid  (hs),
    .in_last   (final_beat),
    .out_valid (p_valid),
    .out_last  (p_last)
  );

endmodule

// File: tb/tb_pe_matrix_ctrl.sv
// Directed bench for pe_matrix_ctrl. Inputs change 2 time units after the
// rising edge, outputs are sampled 1 unit later, mid-cycle.
module tb_pe_matrix_ctrl;
  import pe_ctrl_pkg::*;

  localparam int CNT_W = 16;

  // Expected sel words, column 0 in bits [1:0].
  localparam logic [2*N-1:0] HOLD_ALL = 22'h3FFFFF;  // every column 3
  localparam logic [2*N-1:0] K3_FILL  = 22'h3FFFC0;  // cols 0..2 = 0
  localparam logic [2*N-1:0] K3_DL    = 22'h3FFFC5;  // cols 0,1 = 1, col 2 = 0
  localparam logic [2*N-1:0] K11_FILL = 22'h000000;  // all 11 cols = 0
  localparam logic [2*N-1:0] K2_FILL  = 22'h3FFFF0;  // cols 0,1 = 0
  localparam logic [2*N-1:0] K2_UR    = 22'h3FFFF2;  // col 0 = 2, col 1 = 0

  logic             CLK = 1'b0;
  logic             RST, start, abort, cfg_dir, w_valid, if_valid;
  logic [3:0]       cfg_k;
  logic [CNT_W-1:0] cfg_beats;
  logic             busy, done, cfg_err, rst_w, w_load, if_ready, p_valid, p_last;
  logic [3:0]       w_col;
  logic [N-1:0][1:0] sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pe_matrix_ctrl #(.CNT_W(CNT_W), .PIPE_LAT(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .abort     (abort),
    .cfg_k     (cfg_k),
    .cfg_beats (cfg_beats),
    .cfg_dir   (cfg_dir),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .rst_w     (rst_w),
    .w_valid   (w_valid),
    .w_load    (w_load),
    .w_col     (w_col),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .sel       (sel),
    .p_valid   (p_valid),
    .p_last    (p_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  // Settle, then compare the status outputs common to every cycle.
  task automatic obs(input string tag, input logic b, input logic pv, input logic pl,
                     input logic d, input logic [2*N-1:0] s);
    #1;
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".p_valid"}, 32'(p_valid), 32'(pv));
    check({tag, ".p_last"},  32'(p_last),  32'(pl));
    check({tag, ".done"},    32'(done),    32'(d));
    check({tag, ".cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, ".sel"},     32'(sel),     32'(s));
  endtask

  // Start a job from IDLE with w_valid held high; returns at the first FILL cycle.
  task automatic start_job(input string tag, input logic [3:0] k,
                           input logic [CNT_W-1:0] beats, input logic dir);
    start = 1'b1; cfg_k = k; cfg_beats = beats; cfg_dir = dir;
    w_valid = 1'b1; if_valid = 1'b0;
    obs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle();
    start = 1'b0; cfg_k = 4'd0; cfg_beats = '0; cfg_dir = 1'b0;
    obs({tag, ".clr"}, 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    check({tag, ".clr.rst_w"},  32'(rst_w),  32'd1);
    check({tag, ".clr.w_load"}, 32'(w_load), 32'd0);
    for (int i = 0; i < int'(k); i++) begin
      next_cycle();
      #1;
      check($sformatf("%s.load%0d.w_load", tag, i),   32'(w_load),   32'd1);
      check($sformatf("%s.load%0d.w_col", tag, i),    32'(w_col),    32'(i));
      check($sformatf("%s.load%0d.rst_w", tag, i),    32'(rst_w),    32'd0);
      check($sformatf("%s.load%0d.if_ready", tag, i), 32'(if_ready), 32'd0);
    end
    next_cycle();
    w_valid = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic [3:0] k, input logic [CNT_W-1:0] beats);
    start = 1'b1; cfg_k = k; cfg_beats = beats;
    next_cycle();
    start = 1'b0;
    #1;
    check({tag, ".cfg_err"},  32'(cfg_err), 32'd1);
    check({tag, ".busy"},     32'(busy),    32'd0);
    next_cycle();
    #1;
    check({tag, ".cfg_err_off"}, 32'(cfg_err), 32'd0);
    check({tag, ".busy_off"},    32'(busy),    32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; cfg_k = 4'd0; cfg_beats = '0;
    cfg_dir = 1'b0; w_valid = 1'b0; if_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    obs("reset", 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    check("reset.rst_w",    32'(rst_w),    32'd0);
    check("reset.w_load",   32'(w_load),   32'd0);
    check("reset.w_col",    32'(w_col),    32'd0);
    check("reset.if_ready", 32'(if_ready), 32'd0);
    next_cycle();

    // Job 1: K=3, 4 beats, dir=0, continuous beats.
    start_job("j1", 4'd3, 16'd4, 1'b0);
    if_valid = 1'b1;
    obs("j1.fill", 1'b1, 1'b0, 1'b0, 1'b0, K3_FILL);
    check("j1.fill.if_ready", 32'(if_ready), 32'd1);
    next_cycle(); obs("j1.b2", 1'b1, 1'b0, 1'b0, 1'b0, K3_DL);
    next_cycle(); obs("j1.b3", 1'b1, 1'b1, 1'b0, 1'b0, K3_DL);
    next_cycle(); obs("j1.b4", 1'b1, 1'b1, 1'b0, 1'b0, K3_DL);
    next_cycle(); obs("j1.dr0", 1'b1, 1'b1, 1'b0, 1'b0, HOLD_ALL);
    check("j1.dr0.if_ready", 32'(if_ready), 32'd0);
    next_cycle(); obs("j1.dr1", 1'b1, 1'b1, 1'b1, 1'b0, HOLD_ALL);
    if_valid = 1'b0;
    next_cycle(); obs("j1.done", 1'b0, 1'b0, 1'b0, 1'b1, HOLD_ALL);
    next_cycle(); obs("j1.after", 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle();

    // Job 2: same config, beats with gaps 1,0,1,0,...
    start_job("j2", 4'd3, 16'd4, 1'b0);
    if_valid = 1'b1; obs("j2.fill", 1'b1, 1'b0, 1'b0, 1'b0, K3_FILL);
    next_cycle(); if_valid = 1'b0; obs("j2.g1", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); if_valid = 1'b1; obs("j2.b2", 1'b1, 1'b1, 1'b0, 1'b0, K3_DL);
    next_cycle(); if_valid = 1'b0; obs("j2.g2", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); if_valid = 1'b1; obs("j2.b3", 1'b1, 1'b1, 1'b0, 1'b0, K3_DL);
    next_cycle(); if_valid = 1'b0; obs("j2.g3", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); if_valid = 1'b1; obs("j2.b4", 1'b1, 1'b1, 1'b0, 1'b0, K3_DL);
    next_cycle(); if_valid = 1'b0; obs("j2.dr0", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); obs("j2.dr1", 1'b1, 1'b1, 1'b1, 1'b0, HOLD_ALL);
    next_cycle(); obs("j2.done", 1'b0, 1'b0, 1'b0, 1'b1, HOLD_ALL);
    next_cycle();

    // Job 3: K=11, single beat, dir=1: FILL goes straight to DRAIN.
    start_job("j3", 4'd11, 16'd1, 1'b1);
    if_valid = 1'b1; obs("j3.fill", 1'b1, 1'b0, 1'b0, 1'b0, K11_FILL);
    next_cycle(); if_valid = 1'b0; obs("j3.dr0", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    check("j3.dr0.if_ready", 32'(if_ready), 32'd0);
    next_cycle(); obs("j3.dr1", 1'b1, 1'b1, 1'b1, 1'b0, HOLD_ALL);
    next_cycle(); obs("j3.done", 1'b0, 1'b0, 1'b0, 1'b1, HOLD_ALL);
    next_cycle();

    // Illegal configurations.
    err_case("err_k0",    4'd0,  16'd4);
    err_case("err_k12",   4'd12, 16'd4);
    err_case("err_beat0", 4'd3,  16'd0);

    // Abort after two accepted beats, then a clean K=2 dir=1 job.
    start_job("ab", 4'd3, 16'd4, 1'b0);
    if_valid = 1'b1; obs("ab.fill", 1'b1, 1'b0, 1'b0, 1'b0, K3_FILL);
    next_cycle(); obs("ab.b2", 1'b1, 1'b0, 1'b0, 1'b0, K3_DL);
    next_cycle(); if_valid = 1'b0; abort = 1'b1;
    obs("ab.abort", 1'b1, 1'b1, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); abort = 1'b0;
    obs("ab.idle", 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      obs($sformatf("ab.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    end
    next_cycle();
    start_job("j4", 4'd2, 16'd2, 1'b1);
    if_valid = 1'b1; obs("j4.fill", 1'b1, 1'b0, 1'b0, 1'b0, K2_FILL);
    next_cycle(); obs("j4.b2", 1'b1, 1'b0, 1'b0, 1'b0, K2_UR);
    next_cycle(); if_valid = 1'b0; obs("j4.dr0", 1'b1, 1'b1, 1'b0, 1'b0, HOLD_ALL);
    next_cycle(); obs("j4.dr1", 1'b1, 1'b1, 1'b1, 1'b0, HOLD_ALL);
    next_cycle(); obs("j4.done", 1'b0, 1'b0, 1'b0, 1'b1, HOLD_ALL);
    next_cycle();

    // Start while busy is ignored; RST during LOAD_W returns everything to idle.
    start = 1'b1; cfg_k = 4'd3; cfg_beats = 16'd4; cfg_dir = 1'b0; w_valid = 1'b1;
    next_cycle();
    cfg_k = 4'd0;  // illegal start while busy must not raise cfg_err
    obs("bs.clr", 1'b1, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    check("bs.clr.rst_w", 32'(rst_w), 32'd1);
    next_cycle(); start = 1'b0;
    #1;
    check("bs.load0.cfg_err", 32'(cfg_err), 32'd0);
    check("bs.load0.w_col",   32'(w_col),   32'd0);
    next_cycle();
    #1;
    check("bs.load1.w_col",   32'(w_col),   32'd1);
    RST = 1'b1;
    next_cycle(); RST = 1'b0;
    obs("bs.rst", 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);
    check("bs.rst.w_col",    32'(w_col),    32'd0);
    check("bs.rst.w_load",   32'(w_load),   32'd0);
    check("bs.rst.rst_w",    32'(rst_w),    32'd0);
    check("bs.rst.if_ready", 32'(if_ready), 32'd0);
    next_cycle(); w_valid = 1'b0;
    obs("bs.idle", 1'b0, 1'b0, 1'b0, 1'b0, HOLD_ALL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
